// File: rtl/mc_ctrl_if.sv
// Control bus of mc_ctrl: instruction/flag inputs and datapath control outputs.
// mem_rdy exists only when MC_CTRL_MEMWAIT_EN is defined.
interface mc_ctrl_if;
    logic [31:0] ins;
    logic        zero;
`ifdef MC_CTRL_MEMWAIT_EN
    logic        mem_rdy;
`endif
    logic        pcWr;
    logic        irWr;
    logic        regWr;
    logic        memWr;
    logic        branch;
    logic        jump;
    logic        regDst;
    logic        aluSrc;
    logic        extOp;
    logic        memtoReg;
    logic [3:0]  aluCtr;
    logic [2:0]  state;
    logic        err;

`ifdef MC_CTRL_MEMWAIT_EN
    modport slave (
        input  ins, zero, mem_rdy,
        output pcWr, irWr, regWr, memWr, branch, jump, regDst, aluSrc,
               extOp, memtoReg, aluCtr, state, err
    );
    modport master (
        output ins, zero, mem_rdy,
        input  pcWr, irWr, regWr, memWr, branch, jump, regDst, aluSrc,
               extOp, memtoReg, aluCtr, state, err
    );
`else
    modport slave (
        input  ins, zero,
        output pcWr, irWr, regWr, memWr, branch, jump, regDst, aluSrc,
               extOp, memtoReg, aluCtr, state, err
    );
    modport master (
        output ins, zero,
        input  pcWr, irWr, regWr, memWr, branch, jump, regDst, aluSrc,
               extOp, memtoReg, aluCtr, state, err
    );
`endif
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEMACC/WBACK).
// Optional feature MC_CTRL_MEMWAIT_EN: memory wait states with a timeout abort.
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic       clk,
    input logic       rst,
    mc_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WBACK  = 3'd4
    } state_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    function automatic logic funct_ok(input logic [5:0] fn);
        case (fn)
            F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: funct_ok = 1'b1;
            default:                            funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_dec(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                case (fn)
                    F_SUBU:  alu_dec = 4'b0001;
                    F_AND:   alu_dec = 4'b0011;
                    F_OR:    alu_dec = 4'b0010;
                    F_SLT:   alu_dec = 4'b0100;
                    default: alu_dec = 4'b0000;
                endcase
            end
            OP_ORI:  alu_dec = 4'b0010;
            OP_BEQ:  alu_dec = 4'b0001;
            default: alu_dec = 4'b0000;
        endcase
    endfunction

    state_e     r_state;
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_is_r;
    logic       w_is_ori;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_j;
    logic       w_legal;
    logic       w_rdy;
    logic       w_timeout;
    logic       w_unused;

    assign w_op     = bus.ins[31:26];
    assign w_fn     = bus.ins[5:0];
    assign w_is_r   = (w_op == OP_R) && funct_ok(w_fn);
    assign w_is_ori = (w_op == OP_ORI);
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_beq = (w_op == OP_BEQ);
    assign w_is_j   = (w_op == OP_J);
    assign w_legal  = w_is_r | w_is_ori | w_is_lw | w_is_sw | w_is_beq | w_is_j;

    // zero steers the PC mux in the datapath, never the controller.
    assign w_unused = ^{bus.zero, bus.ins[25:6], TIMEOUT[0]};

`ifdef MC_CTRL_MEMWAIT_EN
    logic [3:0] r_wait_cnt;
    logic       w_waiting;

    assign w_rdy     = bus.mem_rdy;
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMACC);
    assign w_timeout = w_waiting && !w_rdy && (r_wait_cnt == 4'(TIMEOUT - 1));

    // Wait-cycle counter for the current memory access; clears whenever the state is left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 4'd0;
        end else if (w_waiting && !w_rdy && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end
`else
    assign w_rdy     = 1'b1;
    assign w_timeout = 1'b0;
`endif

    // Control FSM state register and next-state selection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= w_rdy ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    if (w_is_j || !w_legal) r_state <= S_FETCH;
                    else                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_is_beq)               r_state <= S_FETCH;
                    else if (w_is_lw || w_is_sw) r_state <= S_MEMACC;
                    else                        r_state <= S_WBACK;
                end
                S_MEMACC: begin
                    if (w_rdy)          r_state <= w_is_sw ? S_FETCH : S_WBACK;
                    else if (w_timeout) r_state <= S_FETCH;
                    else                r_state <= S_MEMACC;
                end
                S_WBACK: r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Write enables and err are gated by rst so they drop the instant reset asserts.
    assign bus.pcWr     = rst && (((r_state == S_FETCH) && w_rdy) ||
                                  ((r_state == S_DECODE) && w_is_j) ||
                                  ((r_state == S_EXEC) && w_is_beq));
    assign bus.irWr     = rst && (r_state == S_FETCH) && w_rdy;
    assign bus.regWr    = rst && (r_state == S_WBACK);
    assign bus.memWr    = rst && (r_state == S_MEMACC) && w_is_sw && w_rdy;
    assign bus.err      = rst && (((r_state == S_DECODE) && !w_legal) || w_timeout);
    assign bus.branch   = (r_state == S_EXEC) && w_is_beq;
    assign bus.jump     = (r_state == S_DECODE) && w_is_j;
    assign bus.regDst   = w_is_r;
    assign bus.aluSrc   = w_is_ori | w_is_lw | w_is_sw;
    assign bus.extOp    = w_is_lw | w_is_sw;
    assign bus.memtoReg = w_is_lw;
    assign bus.aluCtr   = alu_dec(w_op, w_fn);
    assign bus.state    = r_state;

endmodule
